// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the core/DMA memory port arbiter.
// Both the top level and the selector take their counter widths from here.
package mem_arb_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_CORE,
        OWN_DMA
    } arb_owner_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Core-priority selector with an anti-starvation streak counter for DMA.
// Purely combinational select in the arb_en cycle; the streak register updates only on a grant.
module arb_select
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic core_req,
    input  logic dma_req,
    input  logic arb_en,
    output logic sel_core,
    output logic sel_dma
);

    localparam int SW = cnt_w(STARVE_MAX + 1);

    logic [SW-1:0] r_streak;
    logic          w_starved;

    assign w_starved = (r_streak == SW'(STARVE_MAX));

    assign sel_dma  = arb_en & dma_req & (~core_req | w_starved);
    assign sel_core = arb_en & core_req & ~sel_dma;

    // Streak counts core wins that left DMA waiting; any other grant resets it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_streak <= '0;
        end else if (sel_core && dma_req) begin
            if (!w_starved) begin
                r_streak <= r_streak + 1'b1;
            end
        end else if (sel_core || sel_dma) begin
            r_streak <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: one transaction at a time, writes finish in the grant cycle,
// reads return MEM_LAT cycles after grant; requesters hold req until their gnt pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = cnt_w(MEM_LAT);

    arb_state_t    r_state;
    arb_owner_t    r_owner;
    logic [CW-1:0] r_cnt;

    logic w_arb_en;
    logic w_sel_core;
    logic w_sel_dma;
    logic w_grant;
    logic w_grant_we;
    logic w_rd_done;

    // Gating with reset keeps the combinational grant path quiet while reset is held.
    assign w_arb_en = (r_state == IDLE) && !reset;

    arb_select #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb_select (
        .clk      (clk),
        .reset    (reset),
        .core_req (core_req),
        .dma_req  (dma_req),
        .arb_en   (w_arb_en),
        .sel_core (w_sel_core),
        .sel_dma  (w_sel_dma)
    );

    assign w_grant    = w_sel_core | w_sel_dma;
    assign w_grant_we = w_sel_dma ? dma_we : core_we;
    assign w_rd_done  = (r_state == WAIT) && (r_cnt == '0) && !reset;

    assign core_gnt = w_sel_core;
    assign dma_gnt  = w_sel_dma;

    always_comb begin
        mem_en    = w_grant;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_sel_core) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (w_sel_dma) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign core_rvalid = w_rd_done && (r_owner == OWN_CORE);
    assign dma_rvalid  = w_rd_done && (r_owner == OWN_DMA);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign dma_rdata   = dma_rvalid ? mem_rdata : '0;
    assign busy        = (r_state == WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= OWN_CORE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant && !w_grant_we) begin
                        r_owner <= w_sel_dma ? OWN_DMA : OWN_CORE;
                        r_cnt   <= CW'(MEM_LAT - 1);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the multicycle RISC-V core and a DMA/debug requester.
- Accepts one transaction at a time and drives the memory port.
- Returns read data after a fixed memory latency.
- Core has fixed priority, bounded by an anti-starvation counter that guarantees DMA progress.

Parameters:
- AW, 32: address width.
- DW, 32: data width.
- MEM_LAT, 2: cycles from the mem_en read cycle to valid mem_rdata. Legal range is 1 or more.
- STARVE_MAX, 4: maximum consecutive core grants while dma_req is pending.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- core_req  in  1  core request; held with attributes until core_gnt.
- core_we  in  1  core write (1) or read (0).
- core_addr  in  AW  core address.
- core_wdata  in  DW  core write data.
- core_gnt  out  1  one-cycle accept pulse to core.
- core_rvalid  out  1  one-cycle read-data-valid pulse to core.
- core_rdata  out  DW  read data; valid only with core_rvalid, else 0.
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/DW  DMA request, same rules as core.
- dma_gnt, dma_rvalid  out  1  DMA accept and read-valid pulses.
- dma_rdata  out  DW  DMA read data; valid only with dma_rvalid, else 0.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the read strobe.
- busy  out  1  read outstanding (state is not IDLE).

Behaviour:
- Reset value of every output is 0.
  - Forced to 0 while reset is high, including the combinational gnt and mem_en.
- Reset clears the state to IDLE, the latency counter to 0, the streak counter to 0 and the owner to CORE.
- Reset during WAIT discards the outstanding read; no rvalid is ever issued for it.
- States: IDLE and WAIT.
- IDLE, arbitration (combinational, same cycle):
  - If a requester is selected, its gnt is 1, mem_en is 1, and mem_we/mem_addr/mem_wdata are muxed from that requester.
  - No requests: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Selection rule:
  - DMA wins if dma_req=1 and (core_req=0 or streak==STARVE_MAX).
  - Otherwise the core wins if core_req=1.
- Streak counter update, evaluated only on a grant cycle:
  - Core granted while dma_req=1: streak increments, saturating at STARVE_MAX.
  - DMA granted, or core granted with dma_req=0: streak clears to 0.
- Write grant: the write completes in the grant cycle; no rvalid is issued; the FSM stays IDLE. Back-to-back writes therefore run one per cycle.
- Read grant: the owner is registered, the latency counter is loaded with MEM_LAT-1, and the FSM goes to WAIT.
- WAIT, cycle by cycle:
  - No grants are issued; mem_en=0; busy=1.
  - counter>0: decrement.
  - counter==0: owner's rvalid=1 and owner's rdata=mem_rdata (combinational pass-through); next state IDLE.
- Read timing: grant at cycle t gives rvalid at t+MEM_LAT. The earliest next grant is t+MEM_LAT+1.
- Requests arriving during WAIT stay pending. Requesters must hold req and attributes stable until gnt.
- After gnt, a requester may present its next request in the following cycle.
- Simultaneous core and DMA requests with streak<STARVE_MAX: core wins; DMA remains pending.

Decomposition:
- Package mem_arb_pkg contains:
  - arb_state_t enum {IDLE, WAIT}.
  - arb_owner_t enum {OWN_CORE, OWN_DMA}.
- One sub-module, arb_select:
  - Holds the streak counter register and the combinational selection rule.
  - Inputs: clk, reset, core_req, dma_req, arb_en.
  - Outputs: sel_core, sel_dma.
- The top level holds the FSM, latency counter, owner register and data muxes.

Test Plan:
1. Core read, MEM_LAT=2: core_req=1, we=0, addr=0x100 at cycle t -> core_gnt=1 and mem_en=1 at t. At t+1 and t+2, busy=1. core_rvalid=1 with core_rdata equal to the mem_rdata model value (0xDEADBEEF) at t+2. Next grant is possible at t+3.
2. Simultaneous requests: core and DMA both request a write every cycle, streak starts at 0 -> grants are core, core, core, core, dma, core, ... The DMA grant lands on the 5th grant cycle and streak returns to 0.
3. Back-to-back core writes to 0x0, 0x4, 0x8 -> three consecutive cycles with gnt=1, mem_we=1, addrs in order. rvalid and busy stay 0 throughout.
4. DMA read pending while core read is in WAIT -> dma_gnt=0 until the cycle after core_rvalid, then dma_gnt=1. dma_rvalid follows MEM_LAT cycles later; core_rvalid stays 0 during it.
5. Reset asserted asynchronously in the WAIT cycle with counter=1 -> all outputs 0 immediately. After release, no rvalid appears and the next request is granted in IDLE.
6. MEM_LAT=1 build: read grant at t -> rvalid at t+1, next grant at t+2. Idle memory: mem_addr=0, mem_en=0.
